// File: rtl/snake_ctrl_fsm_pkg.sv
// Shared types and helpers for the snake game controller.
// State encodings include PAUSE, which is only reachable when SNAKE_PAUSE_EN is defined.
package snake_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StEat   = 3'd2,
        StHit   = 3'd3,
        StPause = 3'd4,
        StOver  = 3'd5,
        StWin   = 3'd6
    } snake_state_e;

    localparam int unsigned DefWinLen = 6;
    localparam int unsigned DefLives  = 3;

    // Increment that sticks at the all-ones value of a `width`-bit field.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/snake_ctrl_fsm_if.sv
// Playfield-to-controller bus for snake_ctrl_fsm.
// The pause request exists only when SNAKE_PAUSE_EN is defined.
interface snake_ctrl_fsm_if #(
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned SCORE_W = 8
);
    logic               apple;
    logic               head;
    logic               border;
    logic               gameOver;
`ifdef SNAKE_PAUSE_EN
    logic               pause;
`endif
    logic [LEN_W-1:0]   length;
    logic [SCORE_W-1:0] score;
    logic [2:0]         lives_left;
    logic               ld;
    logic               grow;
    logic               i_speaker;
    logic               over;
    logic               win;

    modport master (
`ifdef SNAKE_PAUSE_EN
        output pause,
`endif
        output apple, head, border, gameOver,
        input  length, score, lives_left, ld, grow, i_speaker, over, win
    );

    modport slave (
`ifdef SNAKE_PAUSE_EN
        input  pause,
`endif
        input  apple, head, border, gameOver,
        output length, score, lives_left, ld, grow, i_speaker, over, win
    );

endinterface

// File: rtl/snake_beep_timer.sv
// Speaker beep down-counter: load restarts a BEEP_CYC-cycle beep, hold freezes it.
module snake_beep_timer #(
    parameter int unsigned BEEP_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic hold,
    output logic active
);
    localparam int unsigned CntW = $clog2(BEEP_CYC + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CntW'(BEEP_CYC);
        end else if (!hold && cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    assign active = (cnt_q != '0);

endmodule

// File: rtl/snake_ctrl_fsm.sv
// Snake game control FSM: length, score, lives, edge-qualified eating, beep, over/win.
// Optional macro SNAKE_PAUSE_EN adds the pause request and PAUSE state.
module snake_ctrl_fsm
    import snake_pkg::*;
#(
    parameter int unsigned WIN_LEN  = DefWinLen,
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned SCORE_W  = 8,
    parameter int unsigned LIVES    = DefLives,
    parameter int unsigned BEEP_CYC = 4
) (
    input logic            clk,
    input logic            reset,
    snake_ctrl_fsm_if.slave bus
);
    snake_state_e       state_q, state_d;
    logic [LEN_W-1:0]   length_q;
    logic [SCORE_W-1:0] score_q;
    logic [2:0]         lives_q;
    logic               armed_q;
    logic               ld_q, grow_q, over_q, win_q;
    logic               eat_req, hit_req;
    logic               beep_load, beep_hold, beep_active;

    assign eat_req = bus.head & bus.apple;
    assign hit_req = bus.border | bus.gameOver;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: state_d = StRun;
            StRun: begin
                if (hit_req) begin
                    state_d = StHit;
                end else if (eat_req && armed_q) begin
                    state_d = StEat;
                end else if (length_q == LEN_W'(WIN_LEN)) begin
                    state_d = StWin;
`ifdef SNAKE_PAUSE_EN
                end else if (bus.pause) begin
                    state_d = StPause;
`endif
                end
            end
            StEat: state_d = StRun;
            StHit: state_d = (lives_q == 3'd1) ? StOver : StRun;
`ifdef SNAKE_PAUSE_EN
            StPause: if (!bus.pause) state_d = StRun;
`endif
            StOver:  state_d = StOver;
            StWin:   state_d = StWin;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            length_q <= LEN_W'(1);
            score_q  <= '0;
            lives_q  <= 3'(LIVES);
            armed_q  <= 1'b0;
            ld_q     <= 1'b0;
            grow_q   <= 1'b0;
            over_q   <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_q    <= (state_d == StRun) || (state_d == StEat);
            grow_q  <= (state_d == StEat);
            over_q  <= (state_d == StOver);
            win_q   <= (state_d == StWin);
            case (state_q)
                // Re-arm only once the head has left the apple, so a dwell scores once.
                StRun: if (!eat_req) armed_q <= 1'b1;
                StEat: begin
                    length_q <= LEN_W'(sat_inc(32'(length_q), LEN_W));
                    score_q  <= SCORE_W'(sat_inc(32'(score_q), SCORE_W));
                    armed_q  <= 1'b0;
                end
                StHit: begin
                    lives_q <= lives_q - 3'd1;
                    if (lives_q != 3'd1) begin
                        length_q <= LEN_W'(1);
                        armed_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Loading on the RUN->EAT edge makes the beep visible in the EAT cycle itself.
    assign beep_load = (state_q == StRun) && (state_d == StEat);
`ifdef SNAKE_PAUSE_EN
    assign beep_hold = (state_q == StPause);
`else
    assign beep_hold = 1'b0;
`endif

    snake_beep_timer #(
        .BEEP_CYC(BEEP_CYC)
    ) u_beep (
        .clk   (clk),
        .reset (reset),
        .load  (beep_load),
        .hold  (beep_hold),
        .active(beep_active)
    );

    assign bus.length     = length_q;
    assign bus.score      = score_q;
    assign bus.lives_left = lives_q;
    assign bus.ld         = ld_q;
    assign bus.grow       = grow_q;
    assign bus.over       = over_q;
    assign bus.win        = win_q;
    assign bus.i_speaker  = beep_active | win_q;

endmodule

// File: tb/tb_snake_ctrl_fsm.sv
// Directed self-checking bench for snake_ctrl_fsm (pause checks only with SNAKE_PAUSE_EN).
module tb_snake_ctrl_fsm;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   grow_cnt;
    int   beep_cnt;

    snake_ctrl_fsm_if #(.LEN_W(4), .SCORE_W(8)) bus ();

    snake_ctrl_fsm #(
        .WIN_LEN (6),
        .LEN_W   (4),
        .SCORE_W (8),
        .LIVES   (3),
        .BEEP_CYC(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic h, input logic a, input logic b, input logic g);
        bus.head     = h;
        bus.apple    = a;
        bus.border   = b;
        bus.gameOver = g;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, tallying grow pulses and speaker-high cycles.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            if (bus.grow) grow_cnt++;
            if (bus.i_speaker) beep_cnt++;
        end
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        set_in(0, 0, 0, 0);
`ifdef SNAKE_PAUSE_EN
        bus.pause = 1'b0;
`endif
        #12;
        check("rst_len", 32'(bus.length), 1);
        check("rst_score", 32'(bus.score), 0);
        check("rst_lives", 32'(bus.lives_left), 3);
        check("rst_flags", 32'({bus.ld, bus.grow, bus.i_speaker, bus.over, bus.win}), 0);

        reset = 1'b0;
        cyc();
        check("run_ld", 32'(bus.ld), 1);
        check("run_len", 32'(bus.length), 1);
        check("run_lives", 32'(bus.lives_left), 3);
        cyc();

        // Dwell on one apple for 5 cycles: a single eat, 4 beep cycles.
        grow_cnt = 0;
        beep_cnt = 0;
        set_in(1, 1, 0, 0);
        run(5);
        check("dwell_grow", 32'(grow_cnt), 1);
        check("dwell_beep", 32'(beep_cnt), 4);
        check("dwell_score", 32'(bus.score), 1);
        check("dwell_len", 32'(bus.length), 2);
        set_in(0, 0, 0, 0);
        run(1);
        set_in(1, 1, 0, 0);
        run(1);
        check("eat2_grow", 32'(bus.grow), 1);
        check("eat2_len_lat", 32'(bus.length), 2);
        set_in(0, 0, 0, 0);
        run(5);
        check("two_grows", 32'(grow_cnt), 2);
        check("two_beeps", 32'(beep_cnt), 8);
        check("eat2_score", 32'(bus.score), 2);
        check("eat2_len", 32'(bus.length), 3);
        check("beep_done", 32'(bus.i_speaker), 0);

        // Three more eats reach length 6, then WIN.
        for (int k = 0; k < 3; k++) begin
            set_in(1, 1, 0, 0);
            cyc();
            set_in(0, 0, 0, 0);
            cyc();
            cyc();
        end
        check("win_flag", 32'(bus.win), 1);
        check("win_len", 32'(bus.length), 6);
        check("win_score", 32'(bus.score), 5);
        check("win_spk", 32'(bus.i_speaker), 1);
        check("win_ld", 32'(bus.ld), 0);
        grow_cnt = 0;
        set_in(1, 1, 1, 0);
        run(3);
        check("win_hold", 32'(bus.win), 1);
        check("win_no_over", 32'(bus.over), 0);
        check("win_no_grow", 32'(grow_cnt), 0);
        check("win_lives", 32'(bus.lives_left), 3);
        check("win_spk_hold", 32'(bus.i_speaker), 1);

        // Asynchronous reset from WIN.
        set_in(0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("arst_win", 32'(bus.win), 0);
        check("arst_len", 32'(bus.length), 1);
        check("arst_score", 32'(bus.score), 0);
        check("arst_spk", 32'(bus.i_speaker), 0);
        reset = 1'b0;
        cyc();
        check("arst_run", 32'(bus.ld), 1);
        cyc();
        set_in(1, 1, 0, 0);
        cyc();
        set_in(0, 0, 0, 0);
        cyc();
        check("pre_hit_len", 32'(bus.length), 2);

        // First collision: HIT cycle, then back to RUN with length 1.
        set_in(0, 0, 1, 0);
        cyc();
        check("hit_ld", 32'(bus.ld), 0);
        set_in(0, 0, 0, 0);
        cyc();
        check("hit1_lives", 32'(bus.lives_left), 2);
        check("hit1_len", 32'(bus.length), 1);
        check("hit1_ld", 32'(bus.ld), 1);
        cyc();

        // Collision and apple together: collision wins, no score, no beep.
        grow_cnt = 0;
        beep_cnt = 0;
        set_in(1, 1, 1, 0);
        run(1);
        set_in(0, 0, 0, 0);
        run(1);
        check("coll_grow", 32'(grow_cnt), 0);
        check("coll_beep", 32'(beep_cnt), 0);
        check("hit2_lives", 32'(bus.lives_left), 1);
        check("hit2_score", 32'(bus.score), 1);
        check("hit2_len", 32'(bus.length), 1);
        cyc();

        // Last life via self-collision.
        set_in(0, 0, 0, 1);
        cyc();
        set_in(0, 0, 0, 0);
        cyc();
        check("over_flag", 32'(bus.over), 1);
        check("over_lives", 32'(bus.lives_left), 0);
        check("over_ld", 32'(bus.ld), 0);
        set_in(1, 1, 1, 0);
        cyc();
        cyc();
        check("over_hold", 32'(bus.over), 1);
        check("over_lives_hold", 32'(bus.lives_left), 0);
        set_in(0, 0, 0, 0);

`ifdef SNAKE_PAUSE_EN
        pulse_reset();
        cyc();
        cyc();
        set_in(1, 1, 0, 0);
        cyc();
        set_in(0, 0, 0, 0);
        cyc();
        bus.pause = 1'b1;
        cyc();
        check("pause_ld", 32'(bus.ld), 0);
        check("pause_spk", 32'(bus.i_speaker), 1);
        cyc();
        cyc();
        check("pause_frozen", 32'(bus.i_speaker), 1);
        bus.pause = 1'b0;
        beep_cnt = 0;
        run(4);
        check("resume_ld", 32'(bus.ld), 1);
        check("resume_beep", 32'(beep_cnt), 2);
        bus.pause = 1'b1;
        cyc();
        check("pause2_ld", 32'(bus.ld), 0);
        #2 reset = 1'b1;
        #1;
        check("prst_len", 32'(bus.length), 1);
        check("prst_score", 32'(bus.score), 0);
        check("prst_lives", 32'(bus.lives_left), 3);
        check("prst_flags", 32'({bus.ld, bus.grow, bus.i_speaker, bus.over, bus.win}), 0);
        reset = 1'b0;
        bus.pause = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snake_ctrl_fsm.md
# snake_ctrl_fsm

Parametrised game-control state machine for the snake game, the successor to the fixed-length control unit. It sits between the playfield/collision logic and the display, score and speaker paths. It tracks snake length, a wide score counter and a lives budget, and applies edge-qualified apple eating. It raises a timed speaker beep and signals game-over or win.

## Interface
Parameters:
- `WIN_LEN`, 6: length at which the game is won (1..2^LEN_W-1).
- `LEN_W`, 4: width of `length`.
- `SCORE_W`, 8: width of `score`.
- `LIVES`, 3: lives at game start (1..7).
- `BEEP_CYC`, 4: cycles `i_speaker` stays high per eat (≥1).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous and active-high.
- `apple` in 1: head cell currently holds an apple.
- `head` in 1: head-position-valid qualifier from the playfield.
- `border` in 1: head hit border.
- `gameOver` in 1: self-collision from the body tracker.
- `pause` in 1: level-sensitive pause request (only with `SNAKE_PAUSE_EN`).
- `length` out LEN_W: current length.
- `score` out SCORE_W: apples eaten, saturating.
- `lives_left` out 3: remaining lives.
- `ld` out 1: body-shift enable.
- `grow` out 1: one-cycle pulse per eaten apple.
- `i_speaker` out 1: beep.
- `over` out 1: game lost.
- `win` out 1: game won.

## Operation
- States: IDLE, RUN, EAT, HIT, PAUSE, OVER, WIN. Encodings live in the package.
- IDLE → RUN unconditionally on the next clock.
- RUN priority, highest first:
  1. `border|gameOver` → HIT.
  2. `head&apple&armed` → EAT.
  3. `length==WIN_LEN` → WIN.
  4. `pause` → PAUSE.
  5. Otherwise stay in RUN.
- EAT → RUN always. On the EAT cycle:
  - `length` += 1, saturating at 2^LEN_W-1.
  - `score` += 1, saturating at all-ones.
  - `armed` ← 0.
  - beep counter ← BEEP_CYC.
- `armed` is set to 1 on any RUN cycle where `~(head&apple)`. One apple is therefore scored exactly once, however long the head dwells on it.
- HIT, for one cycle:
  - `lives_left` −1.
  - If the pre-decrement value is 1 → OVER.
  - Otherwise → RUN with `length` reset to 1 and `armed` ← 0.
- PAUSE: → RUN when `pause` deasserts. Collisions and apples are ignored while paused.
- OVER and WIN are terminal. Only `reset` leaves them.
- Outputs are decoded from state as Moore outputs:
  - `ld`=1 in RUN and EAT.
  - `grow`=1 in EAT.
  - `over`=1 in OVER.
  - `win`=1 in WIN.
- `i_speaker` = (beep counter ≠ 0) OR state==WIN. The beep counter decrements every cycle until it reaches 0. A new EAT reloads it; beeps do not queue.
- Reset values:
  - State IDLE.
  - `length`=1, `score`=0, `lives_left`=LIVES.
  - `armed`=0, beep counter=0.
  - All 1-bit outputs 0.

## Timing
- Inputs are sampled on the rising `clk` edge. The state transition and its outputs appear in the same following cycle.
- Eat latency: `head&apple` at edge N → `grow`, `ld`, `i_speaker` high in cycle N+1. `length`/`score` show the new value from cycle N+2.
- `i_speaker` is high for exactly BEEP_CYC cycles starting N+1.
- Simultaneous collision and apple: the collision wins; no score.
- Simultaneous `length==WIN_LEN` and collision: the collision wins.
- Simultaneous `length==WIN_LEN` and apple: the apple wins (EAT); the length is re-checked in the next RUN cycle.
- `reset` mid-game (any state, any beep count) clears everything asynchronously. IDLE is held until `reset` drops, then RUN follows one clock later.

## Configuration
- `SNAKE_PAUSE_EN` defined:
  - The `pause` port and PAUSE state exist.
  - The beep counter also freezes while in PAUSE.
- `SNAKE_PAUSE_EN` undefined:
  - No `pause` port.
  - PAUSE is unreachable and its encoding is unused.
  - RUN rule 4 is removed.

## Structure
- Shared package `snake_pkg`:
  - State encoding constants (3-bit).
  - Default `WIN_LEN`/`LIVES` constants.
  - Saturating-increment function, reused by score and length.
- Sub-module `snake_beep_timer`:
  - Down-counter of width clog2(BEEP_CYC+1).
  - Inputs: load, hold.
  - Output: active.
- Everything else stays flat in `snake_ctrl_fsm`.

## Test plan
- Reset, then one clock → state RUN, `ld`=1, `length`=1, `score`=0, `lives_left`=3.
- Hold `head&apple` for 5 cycles, then drop it, then reassert → exactly two `grow` pulses, `score`=2, `length`=3, `i_speaker` high for 4 cycles after each eat.
- Eat until `length`=6 → `win`=1 and `i_speaker` held high; further apples and `border` are ignored until `reset`.
- Pulse `border` three times with RUN cycles between:
  - 1st and 2nd pulses → `lives_left` 2 then 1, `length` back to 1 each time.
  - 3rd pulse → `over`=1, `lives_left`=0.
- Same cycle `border`=1, `head&apple`=1 → HIT taken, `score` unchanged, no beep.
- With `SNAKE_PAUSE_EN`: assert `pause` mid-beep → `ld`=0 and beep frozen. Deassert → RUN resumes and the beep finishes its remaining cycles. Assert `reset` during PAUSE → IDLE with all reset values.
